ss_clear_sched: RTL and testbench

//  Cyclic-clear scheduler for the store-set predictor (SSIT + LFST).
//  - Counts cycles. Every INTERVAL cycles it walks all SSIT entries and invalidates

---
 rtl/ss_clear_sched.sv | 131 +++++++++++++
 tb/tb_ss_clear_sched.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ss_clear_sched.sv
// Cyclic-clear scheduler for the store-set predictor: periodically walks the SSIT
// through its shared write port, arbitrating against rename training, then flushes the LFST.
module ss_clear_sched #(
    parameter int SSIT_DEPTH = 1024,
    parameter int IDX_W      = 10,
    parameter int INTERVAL   = 1000000,
    parameter int CNT_W      = 20,
    parameter int STARVE_MAX = 16
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             enable_in,
    input  logic             force_in,
    input  logic             train_req_in,
    output logic             train_gnt_out,
    output logic             clr_we_out,
    output logic [IDX_W-1:0] clr_idx_out,
    output logic             lfst_flush_out,
    output logic             pred_disable_out,
    output logic [7:0]       sweep_cnt_out
);

    localparam int STARVE_W = $clog2(STARVE_MAX + 1);

    localparam logic [CNT_W-1:0]    CNT_LAST   = CNT_W'(INTERVAL - 1);
    localparam logic [IDX_W-1:0]    IDX_LAST   = IDX_W'(SSIT_DEPTH - 1);
    localparam logic [STARVE_W-1:0] STARVE_LIM = STARVE_W'(STARVE_MAX);

    typedef enum logic [1:0] {
        S_IDLE,
        S_COUNT,
        S_SWEEP,
        S_FINISH
    } state_t;

    state_t              r_state,     w_state_nxt;
    logic [CNT_W-1:0]    r_counter,   w_counter_nxt;
    logic [IDX_W-1:0]    r_idx,       w_idx_nxt;
    logic [STARVE_W-1:0] r_starve,    w_starve_nxt;
    logic [7:0]          r_sweep_cnt, w_sweep_cnt_nxt;
    logic                w_sweep_win;

    // NOTE: every registered value is updated with <= so all state advances together
    // from the values seen at the same clock edge, independent of statement order.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= S_IDLE;
            r_counter   <= '0;
            r_idx       <= '0;
            r_starve    <= '0;
            r_sweep_cnt <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_counter   <= w_counter_nxt;
            r_idx       <= w_idx_nxt;
            r_starve    <= w_starve_nxt;
            r_sweep_cnt <= w_sweep_cnt_nxt;
        end
    end

    // NOTE: every signal written below gets a default first, so no path through the
    // case statement can leave one unassigned and infer a latch.
    always_comb begin
        w_state_nxt      = r_state;
        w_counter_nxt    = r_counter;
        w_idx_nxt        = r_idx;
        w_starve_nxt     = r_starve;
        w_sweep_cnt_nxt  = r_sweep_cnt;
        w_sweep_win      = 1'b0;
        train_gnt_out    = train_req_in;
        clr_we_out       = 1'b0;
        lfst_flush_out   = 1'b0;
        pred_disable_out = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (enable_in) begin
                    w_state_nxt   = S_COUNT;
                    w_counter_nxt = '0;
                end
            end

            S_COUNT: begin
                w_counter_nxt = r_counter + CNT_W'(1);
                // Disabling wins over a forced start.
                if (!enable_in) begin
                    w_state_nxt   = S_IDLE;
                    w_counter_nxt = '0;
                end else if (r_counter == CNT_LAST || force_in) begin
                    w_state_nxt  = S_SWEEP;
                    w_idx_nxt    = '0;
                    w_starve_nxt = '0;
                end
            end

            S_SWEEP: begin
                pred_disable_out = 1'b1;
                w_sweep_win      = !train_req_in || (r_starve == STARVE_LIM);
                train_gnt_out    = !w_sweep_win;
                clr_we_out       = w_sweep_win;
                if (w_sweep_win) begin
                    w_idx_nxt    = r_idx + IDX_W'(1);
                    w_starve_nxt = '0;
                    if (r_idx == IDX_LAST) begin
                        w_state_nxt = S_FINISH;
                    end
                end else begin
                    w_starve_nxt = r_starve + STARVE_W'(1);
                end
            end

            S_FINISH: begin
                pred_disable_out = 1'b1;
                lfst_flush_out   = 1'b1;
                if (r_sweep_cnt != 8'hFF) begin
                    w_sweep_cnt_nxt = r_sweep_cnt + 8'd1;
                end
                w_counter_nxt = '0;
                w_state_nxt   = enable_in ? S_COUNT : S_IDLE;
            end

            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign clr_idx_out   = r_idx;
    assign sweep_cnt_out = r_sweep_cnt;

endmodule

// File: tb/tb_ss_clear_sched.sv
// Bench for ss_clear_sched: a behavioural model checked every cycle plus directed
// scenarios with hand-computed timing, ordering and saturation expectations.
module tb_ss_clear_sched;

    localparam int SSIT_DEPTH = 8;
    localparam int IDX_W      = 3;
    localparam int INTERVAL   = 20;
    localparam int CNT_W      = 5;
    localparam int STARVE_MAX = 4;

    logic             clock = 1'b0;
    logic             reset_n = 1'b0;
    logic             enable_in = 1'b0;
    logic             force_in = 1'b0;
    logic             train_req_in = 1'b0;
    logic             train_gnt_out;
    logic             clr_we_out;
    logic [IDX_W-1:0] clr_idx_out;
    logic             lfst_flush_out;
    logic             pred_disable_out;
    logic [7:0]       sweep_cnt_out;

    always #5 clock = ~clock;

    ss_clear_sched #(
        .SSIT_DEPTH (SSIT_DEPTH),
        .IDX_W      (IDX_W),
        .INTERVAL   (INTERVAL),
        .CNT_W      (CNT_W),
        .STARVE_MAX (STARVE_MAX)
    ) dut (
        .clock            (clock),
        .reset_n          (reset_n),
        .enable_in        (enable_in),
        .force_in         (force_in),
        .train_req_in     (train_req_in),
        .train_gnt_out    (train_gnt_out),
        .clr_we_out       (clr_we_out),
        .clr_idx_out      (clr_idx_out),
        .lfst_flush_out   (lfst_flush_out),
        .pred_disable_out (pred_disable_out),
        .sweep_cnt_out    (sweep_cnt_out)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    // Behavioural model: phase of the scheduler plus plain integer progress counters.
    typedef enum {M_IDLE, M_COUNT, M_SWEEP, M_FINISH} mode_t;
    mode_t m_mode;
    int    m_cnt, m_idx, m_starve, m_sweeps;

    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            m_mode   <= M_IDLE;
            m_cnt    <= 0;
            m_idx    <= 0;
            m_starve <= 0;
            m_sweeps <= 0;
        end else begin
            case (m_mode)
                M_IDLE: if (enable_in) begin m_mode <= M_COUNT; m_cnt <= 0; end
                M_COUNT: begin
                    if (!enable_in) begin m_mode <= M_IDLE; m_cnt <= 0; end
                    else if (m_cnt == INTERVAL - 1 || force_in) begin
                        m_mode <= M_SWEEP; m_idx <= 0; m_starve <= 0;
                    end else m_cnt <= m_cnt + 1;
                end
                M_SWEEP: begin
                    if (!train_req_in || m_starve == STARVE_MAX) begin
                        m_starve <= 0;
                        if (m_idx == SSIT_DEPTH - 1) begin m_mode <= M_FINISH; m_idx <= 0; end
                        else m_idx <= m_idx + 1;
                    end else m_starve <= m_starve + 1;
                end
                M_FINISH: begin
                    m_sweeps <= (m_sweeps < 255) ? m_sweeps + 1 : 255;
                    m_cnt    <= 0;
                    m_mode   <= enable_in ? M_COUNT : M_IDLE;
                end
                default: m_mode <= M_IDLE;
            endcase
        end
    end

    // Observation log used by the directed checks.
    int cyc = 0;
    int flush_seen, first_clr_cyc, flush_cyc;
    int sweep_cycles, sweep_gnts, both_high, bad_clr;
    int clr_log[$];

    always @(negedge clock) begin
        bit in_sweep;
        bit win;
        cyc++;
        in_sweep = (m_mode == M_SWEEP);
        win      = in_sweep && (!train_req_in || m_starve == STARVE_MAX);
        check("train_gnt", train_gnt_out, in_sweep ? !win : train_req_in);
        check("clr_we", clr_we_out, win);
        check("clr_idx", clr_idx_out, m_idx);
        check("lfst_flush", lfst_flush_out, m_mode == M_FINISH);
        check("pred_disable", pred_disable_out, in_sweep || m_mode == M_FINISH);
        check("sweep_cnt", sweep_cnt_out, m_sweeps);

        if (clr_we_out === 1'b1) begin
            clr_log.push_back(int'(clr_idx_out));
            if (first_clr_cyc < 0) first_clr_cyc = cyc;
        end
        if (lfst_flush_out === 1'b1) begin
            flush_seen++;
            if (flush_cyc < 0) flush_cyc = cyc;
        end
        if (pred_disable_out === 1'b1 && lfst_flush_out === 1'b0) begin
            sweep_cycles++;
            if (train_gnt_out === 1'b1) sweep_gnts++;
        end
        if (train_gnt_out === 1'b1 && clr_we_out === 1'b1) both_high++;
        if (clr_we_out === 1'b1 && train_req_in === 1'b1) bad_clr++;
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic clear_logs();
        clr_log.delete();
        flush_seen    = 0;
        first_clr_cyc = -1;
        flush_cyc     = -1;
        sweep_cycles  = 0;
        sweep_gnts    = 0;
        both_high     = 0;
        bad_clr       = 0;
    endtask

    task automatic wait_flush(input string name, input int target, input int bound);
        int n;
        n = 0;
        while (flush_seen < target && n < bound) begin
            tick(1);
            n++;
        end
        check({name, "_flush_timeout"}, flush_seen >= target, 1);
    endtask

    task automatic check_order(input string name);
        check({name, "_clr_count"}, clr_log.size(), SSIT_DEPTH);
        for (int i = 0; i < clr_log.size() && i < SSIT_DEPTH; i++)
            check({name, "_clr_order"}, clr_log[i], i);
    endtask

    initial begin
        int rel;
        clear_logs();

        // 1: reset, periodic sweep with no training traffic.
        enable_in = 1'b1;
        tick(3);
        check("rst_clr_we", clr_we_out, 0);
        check("rst_pred", pred_disable_out, 0);
        check("rst_flush", lfst_flush_out, 0);
        check("rst_cnt", sweep_cnt_out, 0);
        check("rst_idx", clr_idx_out, 0);
        check("rst_gnt", train_gnt_out, 0);
        reset_n = 1'b1;
        clear_logs();
        rel = cyc;
        wait_flush("t1", 1, 60);
        check("t1_first_clr_lat", first_clr_cyc - rel, 22);
        check("t1_flush_lat", flush_cyc - rel, 30);
        check("t1_sweep_len", sweep_cycles, 8);
        check_order("t1");
        check("t1_flushes", flush_seen, 1);
        check("t1_sweep_cnt", sweep_cnt_out, 1);

        // 2: training held for the whole sweep; starvation guard paces the clears.
        train_req_in = 1'b1;
        clear_logs();
        wait_flush("t2", 1, 150);
        check("t2_sweep_len", sweep_cycles, 40);
        check("t2_grants", sweep_gnts, 32);
        check("t2_first_to_flush", flush_cyc - first_clr_cyc, 36);
        check_order("t2");
        check("t2_sweep_cnt", sweep_cnt_out, 2);

        // 3: forced start, force and disable ignored mid-sweep.
        train_req_in = 1'b0;
        tick(5);
        clear_logs();
        force_in = 1'b1;
        tick(1);
        force_in = 1'b0;
        check("t3_pred_now", pred_disable_out, 1);
        check("t3_clr_now", clr_we_out, 1);
        check("t3_idx_now", clr_idx_out, 0);
        tick(2);
        force_in  = 1'b1;
        enable_in = 1'b0;
        tick(1);
        force_in = 1'b0;
        wait_flush("t3", 1, 20);
        check_order("t3");
        check("t3_sweep_cnt", sweep_cnt_out, 3);
        check("t3_idle_pred", pred_disable_out, 0);
        clear_logs();
        tick(25);
        check("t3_idle_clrs", clr_log.size(), 0);
        check("t3_idle_flush", flush_seen, 0);
        enable_in = 1'b1;
        tick(1);
        enable_in = 1'b0;
        force_in  = 1'b1;
        tick(1);
        force_in = 1'b0;
        tick(2);
        check("t3_disable_prio", pred_disable_out, 0);

        // 4: asynchronous reset in the middle of a sweep.
        enable_in = 1'b1;
        tick(1);
        force_in = 1'b1;
        tick(1);
        force_in = 1'b0;
        tick(3);
        check("t4_idx3", clr_idx_out, 3);
        check("t4_we3", clr_we_out, 1);
        #2 reset_n = 1'b0;
        #1;
        check("t4_rst_we", clr_we_out, 0);
        check("t4_rst_idx", clr_idx_out, 0);
        check("t4_rst_pred", pred_disable_out, 0);
        check("t4_rst_cnt", sweep_cnt_out, 0);
        clear_logs();
        enable_in = 1'b0;
        @(posedge clock);
        #1 reset_n = 1'b1;
        tick(30);
        check("t4_no_flush", flush_seen, 0);
        check("t4_no_clr", clr_log.size(), 0);
        check("t4_cnt_after", sweep_cnt_out, 0);

        // 6: alternating training requests; clears only in gaps.
        enable_in = 1'b1;
        tick(1);
        clear_logs();
        force_in = 1'b1;
        tick(1);
        force_in = 1'b0;
        for (int i = 0; i < 40 && flush_seen == 0; i++) begin
            train_req_in = (i % 2 == 0);
            tick(1);
        end
        train_req_in = 1'b0;
        check("t6_flush", flush_seen, 1);
        check_order("t6");
        check("t6_clr_on_req", bad_clr, 0);
        check("t6_both_high", both_high, 0);
        check("t6_grants", sweep_gnts, 8);
        check("t6_sweep_cnt", sweep_cnt_out, 1);

        // 5: many forced sweeps; counter saturates, flush keeps pulsing.
        clear_logs();
        for (int k = 0; k < 256; k++) begin
            force_in = 1'b1;
            tick(1);
            force_in = 1'b0;
            wait_flush("t5", k + 1, 30);
            if (k == 252) check("t5_cnt_pre_sat", sweep_cnt_out, 254);
        end
        check("t5_flushes", flush_seen, 256);
        check("t5_sat", sweep_cnt_out, 255);
        check("t5_clrs", clr_log.size(), 256 * SSIT_DEPTH);

        tick(2);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
